// File: rtl/keypad_pkg.sv
// Shared types and default sizing for the doorlock keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {RELEASED, PRESS_PEND, HELD, REL_PEND} deb_state_e;
  typedef enum logic [1:0] {NONE, ONE, MULTI} frame_res_e;

  localparam int DEF_N_ROWS         = 4;
  localparam int DEF_N_COLS         = 4;
  localparam int DEF_SCAN_DIV       = 4;
  localparam int DEF_DEBOUNCE_SCANS = 3;
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_REPEAT_DELAY   = 20;
  localparam int DEF_REPEAT_RATE    = 5;

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO whose head word and valid flag are registered,
// so the consumer sees a clean output one cycle after the first push.
module key_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q;
  logic             full, do_pop, do_push;

  always_comb begin
    full     = (count_q == (PW+1)'(DEPTH));
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && (!full || do_pop);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    head_d   = head_q;
    if (count_d == '0)
      head_d = '0;
    else if ((count_q - (PW+1)'(do_pop)) == '0)
      head_d = din_i;  // word arriving into an otherwise empty FIFO bypasses storage
    else
      head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = head_q;
  assign valid_o = valid_q;
  assign count_o = count_q;
  assign drop_o  = push_i && full && !do_pop;

endmodule

// File: rtl/keypad_scan_fifo.sv
// Keypad matrix scanner with per-frame debounce, ghost-key rejection and key FIFO.
// Optional auto-repeat of a held key is built when AUTO_REPEAT_EN is defined.
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int N_ROWS         = DEF_N_ROWS,
  parameter int N_COLS         = DEF_N_COLS,
  parameter int SCAN_DIV       = DEF_SCAN_DIV,
  parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH
`ifdef AUTO_REPEAT_EN
  , parameter int REPEAT_DELAY = DEF_REPEAT_DELAY
  , parameter int REPEAT_RATE  = DEF_REPEAT_RATE
`endif
  , localparam int CODE_W      = $clog2(N_ROWS*N_COLS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_COLS-1:0]             col_matrix,
  output logic [N_ROWS-1:0]             lin_matrix,
  output logic [CODE_W-1:0]             key_code,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int RW = $clog2(N_ROWS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  logic [RW-1:0]     row_q;
  logic [DW-1:0]     dwell_q;
  logic              sample, frame_end;
  logic [1:0]        row_n, acc_n_q, tot_n;
  logic [2:0]        sum_n;
  logic [CODE_W-1:0] row_code, acc_code_q, tot_code;
  frame_res_e        res;
  logic              match;
  deb_state_e        st_q, st_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic              push, push_all, drop;
  logic              ovf_q;

  assign sample     = (dwell_q == DW'(SCAN_DIV-1));
  assign frame_end  = sample && (row_q == RW'(N_ROWS-1));
  assign lin_matrix = ~(N_ROWS'(1) << row_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      dwell_q <= '0;
    end else if (sample) begin
      dwell_q <= '0;
      row_q   <= frame_end ? '0 : row_q + RW'(1);
    end else begin
      dwell_q <= dwell_q + DW'(1);
    end
  end

  // Per-row column decode, saturating key count at 2 (anything above is MULTI)
  always_comb begin
    row_n    = 2'd0;
    row_code = '0;
    for (int c = 0; c < N_COLS; c++) begin
      if (!col_matrix[c]) begin
        if (row_n == 2'd0) row_code = CODE_W'(int'(row_q) * N_COLS + c);
        if (row_n != 2'd2) row_n = row_n + 2'd1;
      end
    end
    sum_n    = {1'b0, acc_n_q} + {1'b0, row_n};
    tot_n    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
    tot_code = (acc_n_q == 2'd0) ? row_code : acc_code_q;
    res      = (tot_n == 2'd0) ? NONE : (tot_n == 2'd1) ? ONE : MULTI;
    match    = (res == ONE) && (tot_code == cand_q);
    cnt_inc  = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) acc_n_q <= 2'd0;
    else if (sample) acc_n_q <= frame_end ? 2'd0 : tot_n;
  end

  always_ff @(posedge clk) begin
    if (sample) acc_code_q <= tot_code;
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    cand_d = cand_q;
    push   = 1'b0;
    if (frame_end) begin
      case (st_q)
        RELEASED: if (res == ONE) begin
          cand_d = tot_code;
          cnt_d  = CW'(1);
          if (DEBOUNCE_SCANS == 1) begin
            push = 1'b1;
            st_d = HELD;
          end else begin
            st_d = PRESS_PEND;
          end
        end
        PRESS_PEND: begin
          if (match) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              push = 1'b1;
              st_d = HELD;
            end
          end else if (res == ONE) begin
            cand_d = tot_code;
            cnt_d  = CW'(1);
          end else begin
            st_d = RELEASED;
          end
        end
        HELD: if (res == NONE) begin
          cnt_d = CW'(1);
          st_d  = (DEBOUNCE_SCANS == 1) ? RELEASED : REL_PEND;
        end
        REL_PEND: begin
          if (res == NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) st_d = RELEASED;
          end else begin
            st_d = HELD;
          end
        end
        default: st_d = RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= RELEASED;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    cand_q <= cand_d;
  end

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW  = $clog2(RMAX+1);

  logic [RPW-1:0] rep_q, rep_d;
  logic           armed_q, armed_d, rep_push;

  // First repeat waits REPEAT_DELAY frames, later ones REPEAT_RATE frames
  always_comb begin
    rep_d    = rep_q;
    armed_d  = armed_q;
    rep_push = 1'b0;
    if (st_q != HELD || st_d != HELD) begin
      rep_d   = '0;
      armed_d = 1'b0;
    end else if (frame_end && match) begin
      rep_d = rep_q + RPW'(1);
      if (rep_d == (armed_q ? RPW'(REPEAT_RATE) : RPW'(REPEAT_DELAY))) begin
        rep_push = 1'b1;
        rep_d    = '0;
        armed_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      rep_q   <= rep_d;
      armed_q <= armed_d;
    end
  end

  assign push_all = push || rep_push;
`else
  assign push_all = push;
`endif

  key_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_all),
    .din_i   (tot_code),
    .pop_i   (key_ready),
    .dout_o  (key_code),
    .valid_o (key_valid),
    .count_o (fifo_count),
    .drop_o  (drop)
  );

  // A drop in the same cycle as clr_ovf keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
    else if (clr_ovf) ovf_q <= 1'b0;
  end

  assign overflow = ovf_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo on a 4x4 pad, 16-cycle frames.
module tb_keypad_scan_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_matrix;
  logic [3:0] lin_matrix;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       clr_ovf = 1'b0;
  logic [15:0] keys = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  keypad_scan_fifo #(
    .N_ROWS(4), .N_COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3), .FIFO_DEPTH(4)
`ifdef AUTO_REPEAT_EN
    , .REPEAT_DELAY(4), .REPEAT_RATE(2)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col_matrix (col_matrix),
    .lin_matrix (lin_matrix),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  // Keypad model: a pressed key pulls its column low while its row is driven
  always_comb begin
    col_matrix = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!lin_matrix[r] && keys[r*4+c]) col_matrix[c] = 1'b0;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    keys = '0;
    key_ready = 1'b0;
    clr_ovf = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] e;

    // Idle scanning after reset
    do_reset();
    chk("rst_valid", key_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_code", key_code, 0);
    for (int i = 0; i < 16; i++) begin
      e = ~(4'b0001 << (i % 4));
      chk("lin_scan", lin_matrix, e);
      cyc(4);
    end
    chk("idle_valid", key_valid, 0);
    chk("idle_count", fifo_count, 0);

    // Single held key row2/col1 -> code 9 after three frames
    do_reset();
    keys[9] = 1'b1;
    cyc(47);
    chk("hold_before", key_valid, 0);
    cyc(1);
    chk("hold_valid", key_valid, 1);
    chk("hold_code", key_code, 9);
    chk("hold_count", fifo_count, 1);
    cyc(160);
`ifndef AUTO_REPEAT_EN
    chk("hold_nopush", fifo_count, 1);
`endif
    cyc(5);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midrst_valid", key_valid, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_code", key_code, 0);
    chk("midrst_lin", lin_matrix, 4'b1110);

    // Bounce: on frame 0, off frame 1, on from frame 2
    do_reset();
    keys[6] = 1'b1;
    cyc(16);
    keys[6] = 1'b0;
    cyc(16);
    keys[6] = 1'b1;
    cyc(47);
    chk("bounce_before", key_valid, 0);
    cyc(1);
    chk("bounce_valid", key_valid, 1);
    chk("bounce_code", key_code, 6);

    // Ghost: keys 5 and 6 together, then 6 released
    do_reset();
    keys[5] = 1'b1;
    keys[6] = 1'b1;
    cyc(80);
    chk("multi_nopush", key_valid, 0);
    keys[6] = 1'b0;
    cyc(47);
    chk("multi_before", key_valid, 0);
    cyc(1);
    chk("multi_valid", key_valid, 1);
    chk("multi_code", key_code, 5);

    // Five presses into a four-deep FIFO
    do_reset();
    for (int i = 0; i < 5; i++) begin
      keys = 16'(1) << i;
      cyc(48);
      chk("fill_count", fifo_count, (i < 4) ? i + 1 : 4);
      keys = '0;
      cyc(48);
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_head", key_code, 0);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    chk("ovf_clr", overflow, 0);
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pop_valid", key_valid, 1);
      chk("pop_code", key_code, i);
      cyc(1);
    end
    chk("drain_valid", key_valid, 0);
    chk("drain_count", fifo_count, 0);
    key_ready = 1'b0;

`ifdef AUTO_REPEAT_EN
    // Auto-repeat of key 15: pushes at ends of frames 2, 6, 8, 10
    do_reset();
    keys[15] = 1'b1;
    cyc(47);
    chk("rep_f2_before", fifo_count, 0);
    cyc(1);
    chk("rep_f2", fifo_count, 1);
    chk("rep_code", key_code, 15);
    cyc(63);
    chk("rep_f6_before", fifo_count, 1);
    cyc(1);
    chk("rep_f6", fifo_count, 2);
    cyc(32);
    chk("rep_f8", fifo_count, 3);
    cyc(32);
    chk("rep_f10", fifo_count, 4);
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rep_rst_valid", key_valid, 0);
    chk("rep_rst_count", fifo_count, 0);
    chk("rep_rst_code", key_code, 0);
    chk("rep_rst_ovf", overflow, 0);
    chk("rep_rst_lin", lin_matrix, 4'b1110);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
